// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, start/busy/done handshake.
// Optional build macro MUL_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  // Handshake: a request is taken on any edge where start=1 and the unit is in
  // IDLE or DONE; busy is high while it runs; done pulses for one cycle with
  // result valid, and result is held until the next accepted request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t            state;
  logic [1:0]        op;
  logic              neg;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] acc;

  logic              sgn1, sgn2, neg1, neg2, accept, run_last;
  logic [XLEN-1:0]   mag1, mag2, mplier_shift;
  logic [2*XLEN-1:0] acc_sum, acc_fix;

  assign sgn1   = (mulctl == OP_MULH) || (mulctl == OP_MULHSU);
  assign sgn2   = (mulctl == OP_MULH);
  assign neg1   = sgn1 & rs1[XLEN-1];
  assign neg2   = sgn2 & rs2[XLEN-1];
  // The most-negative value negates to 2^(XLEN-1), which is still correct unsigned.
  assign mag1   = neg1 ? -rs1 : rs1;
  assign mag2   = neg2 ? -rs2 : rs2;
  assign accept = start && ((state == IDLE) || (state == DONE));

  assign mplier_shift = mplier >> 1;
  assign acc_sum      = mplier[0] ? (acc + mcand) : acc;
  assign acc_fix      = neg ? -acc : acc;

`ifdef MUL_EARLY_TERM_EN
  assign run_last = (mplier_shift == '0) || (cnt == LAST);
`else
  assign run_last = (cnt == LAST);
`endif

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op     <= mulctl;
            neg    <= neg1 ^ neg2;
            mcand  <= {{XLEN{1'b0}}, mag1};
            mplier <= mag2;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_shift;
          cnt    <= cnt + 1'b1;
          if (run_last) state <= FIX;
        end
        FIX: begin
          // Sign fix and result selection share one edge so result is valid with done.
          acc    <= acc_fix;
          result <= (op == OP_MUL) ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vectors, scoreboard queue, done-driven monitor.
module tb_mul_unit;

  localparam int XLEN = 32;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mulctl = 2'b00;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [XLEN-1:0] exp_q[$];
  int              due_q[$];
  string           name_q[$];

  mul_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .mulctl(mulctl), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cycles from the start cycle to the done cycle.
  function automatic int lat_of(logic [1:0] op, logic [XLEN-1:0] b);
    logic [XLEN-1:0] m;
    int len;
    m = (op == 2'b01 && b[XLEN-1]) ? -b : b;
    len = 1;
    for (int i = 0; i < XLEN; i++) if (m[i]) len = i + 1;
    return EARLY ? len + 2 : XLEN + 2;
  endfunction

  task automatic check(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation (value and arrival cycle).
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        logic [XLEN-1:0] e;
        int d;
        string n;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        n = name_q.pop_front();
        check(n, result, e);
        check({n, "_cycle"}, XLEN'(cyc), XLEN'(d));
      end
    end
  end

  // Drivers
  task automatic issue(string nm, logic [1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                       logic [XLEN-1:0] exp, bit track);
    @(negedge clk);
    start = 1'b1;
    mulctl = op;
    rs1 = a;
    rs2 = b;
    if (track) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + lat_of(op, b));
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    mulctl = 2'($urandom_range(0, 3));
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
      name_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int l;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", XLEN'(busy), '0);
    check("reset_done", XLEN'(done), '0);
    check("reset_result", result, '0);
    check("reset_state", XLEN'(dbg_state), '0);

    // Basic MUL with per-cycle busy/done timing
    issue("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b1);
    l = lat_of(2'b00, 32'd6);
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      check("t1_busy", XLEN'(busy), XLEN'(k < l));
      check("t1_done", XLEN'(done), XLEN'(k == l));
    end
    wait_done();

    // Most-negative squared, then back-to-back MUL issued in the DONE cycle
    issue("mulh_min_sq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
    l = lat_of(2'b01, 32'h80000000);
    repeat (l - 1) @(negedge clk);
    issue("mul_min_sq_b2b", 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    wait_done();

    issue("mulhu_ones", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    wait_done();
    issue("mulh_ones", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    wait_done();
    issue("mulhsu_ones", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    check("result_hold", result, 32'hFFFFFFFF);
    check("idle_busy", XLEN'(busy), '0);

    issue("mul_m7x6", 2'b00, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b1);
    wait_done();
    issue("mulh_m7x6", 2'b01, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 1'b1);
    wait_done();
    issue("mulhsu_5xmax", 2'b10, 32'd5, 32'hFFFFFFFF, 32'h00000004, 1'b1);
    wait_done();
    issue("mulh_m3xm5", 2'b01, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 1'b1);
    wait_done();

    // start while busy must be ignored
    issue("mul_3x5_ignore", 2'b00, 32'd3, 32'd5, 32'd15, 1'b1);
    repeat (EARLY ? 1 : 4) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    mulctl = 2'b00;
    rs1 = 32'd9;
    rs2 = 32'd9;
    check("busy_at_ignored_start", XLEN'(busy), 1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts with no done pulse
    issue("abort", 2'b00, 32'd3, 32'h80000000, '0, 1'b0);
    repeat (9) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", XLEN'(busy), '0);
    check("abort_done", XLEN'(done), '0);
    check("abort_result", result, '0);
    check("abort_state", XLEN'(dbg_state), '0);
    repeat (40) @(negedge clk);

    // Reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    mulctl = 2'b00;
    rs1 = 32'd2;
    rs2 = 32'd2;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", XLEN'(busy), '0);
    check("rst_start_state", XLEN'(dbg_state), '0);
    repeat (40) @(negedge clk);

    issue("mul_2x2_recover", 2'b00, 32'd2, 32'd2, 32'd4, 1'b1);
    wait_done();

`ifdef MUL_EARLY_TERM_EN
    issue("et_mul_5x3", 2'b00, 32'd5, 32'd3, 32'd15, 1'b1);
    wait_done();
    issue("et_mulhu_1xmsb", 2'b11, 32'd1, 32'h80000000, 32'h00000000, 1'b1);
    wait_done();
    issue("et_mul_x0", 2'b00, 32'h12345678, 32'd0, 32'h00000000, 1'b1);
    wait_done();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
